// File: rtl/hififo_rr_arbiter.sv
// Round-robin arbiter sharing the PCIe memory-read request path between NREQ requesters.
// Allocates read tags from a 2^TAGBITS pool and routes completion-last pulses to each tag's owner.
module hififo_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int OBITS   = 2,
  parameter int AMSB    = 63,
  parameter int TAGBITS = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*(AMSB+1)-1:0] req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tlp_valid,
  output logic [AMSB:0]            tlp_addr,
  output logic [TAGBITS-1:0]       tlp_tag,
  input  logic                     tlp_ready,
  input  logic                     rc_valid,
  input  logic [TAGBITS-1:0]       rc_tag,
  input  logic                     rc_last_in,
  output logic [OBITS-1:0]         rc_owner,
  output logic [NREQ-1:0]          rc_last,
  output logic [TAGBITS:0]         tags_free,
  output logic                     tag_error
);
  localparam int NTAGS = 1 << TAGBITS;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t             r_state;
  logic [OBITS-1:0]   r_ptr;
  logic [OBITS-1:0]   r_grant;
  logic [AMSB:0]      r_tlp_addr;
  logic [TAGBITS-1:0] r_tlp_tag;
  logic [NTAGS-1:0]   r_busy;
  logic [OBITS-1:0]   r_owner [NTAGS];
  logic [NREQ-1:0]    r_rc_last;
  logic               r_tag_error;

  logic [AMSB:0]      w_addr [NREQ];
  logic [NREQ-1:0]    w_at_or_after;
  logic [NREQ-1:0]    w_upper;
  logic               w_found;
  logic [OBITS-1:0]   w_grant;
  logic [AMSB:0]      w_sel_addr;
  logic               w_tag_avail;
  logic [TAGBITS-1:0] w_free_tag;
  logic               w_alloc;
  logic               w_accept;
  logic               w_rc_end;
  logic               w_rc_done;
  logic               w_rc_bad;
  logic [NTAGS-1:0]   w_busy_next;
  logic [NREQ-1:0]    w_rc_last_next;
  logic [TAGBITS:0]   w_busy_cnt;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_addr[gi]         = req_addr[gi*(AMSB+1) +: AMSB+1];
      assign w_at_or_after[gi]  = (OBITS'(gi) >= r_ptr);
      assign req_ready[gi]      = w_accept && (r_grant == OBITS'(gi));
      assign w_rc_last_next[gi] = w_rc_done && (r_owner[rc_tag] == OBITS'(gi));
    end
  endgenerate

  assign w_upper = req_valid & w_at_or_after;

  // Requesters at or after the pointer win; if none, wrap around to the lowest index.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_sel_addr = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if ((w_upper != '0) ? w_upper[i] : req_valid[i]) begin
        w_found    = 1'b1;
        w_grant    = OBITS'(i);
        w_sel_addr = w_addr[i];
      end
    end
  end

  always_comb begin
    w_tag_avail = 1'b0;
    w_free_tag  = '0;
    for (int t = NTAGS - 1; t >= 0; t--) begin
      if (!r_busy[t]) begin
        w_tag_avail = 1'b1;
        w_free_tag  = TAGBITS'(t);
      end
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int t = 0; t < NTAGS; t++) begin
      w_busy_cnt = w_busy_cnt + (TAGBITS+1)'(r_busy[t]);
    end
  end

  assign w_accept  = (r_state == S_PRESENT) && tlp_ready;
  assign w_alloc   = (r_state == S_IDLE) && w_found && w_tag_avail;
  assign w_rc_end  = rc_valid && rc_last_in;
  assign w_rc_done = w_rc_end && r_busy[rc_tag];
  assign w_rc_bad  = w_rc_end && !r_busy[rc_tag];

  // Allocation picks from the pre-free mask, so a freed tag and the new tag never collide.
  always_comb begin
    w_busy_next = r_busy;
    if (w_rc_done) w_busy_next[rc_tag] = 1'b0;
    if (w_alloc)   w_busy_next[w_free_tag] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_tlp_addr  <= '0;
      r_tlp_tag   <= '0;
      r_busy      <= '0;
      r_rc_last   <= '0;
      r_tag_error <= 1'b0;
      for (int t = 0; t < NTAGS; t++) r_owner[t] <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_rc_last <= w_rc_last_next;
      if (w_rc_bad) r_tag_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_alloc) begin
            r_state             <= S_PRESENT;
            r_grant             <= w_grant;
            r_tlp_addr          <= w_sel_addr;
            r_tlp_tag           <= w_free_tag;
            r_owner[w_free_tag] <= w_grant;
          end
        end
        S_PRESENT: begin
          if (tlp_ready) begin
            r_state <= S_IDLE;
            r_ptr   <= (r_grant == OBITS'(NREQ - 1)) ? '0 : r_grant + OBITS'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tlp_valid = (r_state == S_PRESENT);
  assign tlp_addr  = r_tlp_addr;
  assign tlp_tag   = r_tlp_tag;
  assign rc_owner  = r_owner[rc_tag];
  assign rc_last   = r_rc_last;
  assign tag_error = r_tag_error;
  assign tags_free = (TAGBITS+1)'(NTAGS) - w_busy_cnt;

endmodule
